// File: rtl/reaction_timer_system_pkg.sv
`default_nettype none
// ============================================================================
// reaction_timer_system_pkg : FSM states, LED codes, widths, LFSR step
// Rev 1.0
// ============================================================================
package reaction_timer_system_pkg;

  localparam int RT_W   = 10;
  localparam int RND_W  = 13;
  localparam int WAIT_W = 13;

  localparam logic [7:0] LED_ON  = 8'hFF;
  localparam logic [7:0] LED_OFF = 8'h00;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM_UPD = 3'd1;
  localparam logic [2:0] S_ARM_REL = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_GO      = 3'd4;
  localparam logic [2:0] S_REP_UPD = 3'd5;
  localparam logic [2:0] S_REP_REL = 3'd6;

  // Fibonacci step, taps 13,12,11,8, feedback enters at bit 0
  function automatic logic [RND_W-1:0] lfsr_next(input logic [RND_W-1:0] s);
    return {s[RND_W-2:0], s[12] ^ s[11] ^ s[10] ^ s[7]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_timer_system_random_gen.sv
`default_nettype none
// ============================================================================
// random_gen : free-running 13-bit LFSR with all-zero recovery
// Rev 1.0
// ============================================================================
module random_gen
  import reaction_timer_system_pkg::*;
#(
  parameter logic [RND_W-1:0] LFSR_SEED = 13'h1ACE
) (
  input  logic             Clk,
  input  logic             Rst,
  output logic [RND_W-1:0] RandomValue
);

  logic [RND_W-1:0] r_lfsr;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_lfsr == '0) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign RandomValue = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/reaction_timer_system.sv
`default_nettype none
// ============================================================================
// reaction_timer_system : reaction-time game FSM with LCD Update/Ack reporting
// Rev 1.0
// ============================================================================
module reaction_timer_system
  import reaction_timer_system_pkg::*;
#(
  parameter int               MIN_WAIT   = 1000,
  parameter int               SLOW_LIMIT = 500,
  parameter int               MAX_COUNT  = 1023,
  parameter logic [RND_W-1:0] LFSR_SEED  = 13'h1ACE
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             LCDAck,
  output logic [7:0]       LED,
  output logic [RT_W-1:0]  ReactionTime,
  output logic             Cheat,
  output logic             Slow,
  output logic             Wait,
  output logic             LCDUpdate,
  output logic [RND_W-1:0] RandomValue
);

  localparam logic [RT_W-1:0]   C_MAX_CNT  = RT_W'(MAX_COUNT);
  localparam logic [RT_W-1:0]   C_SLOW_LIM = RT_W'(SLOW_LIMIT);
  localparam logic [WAIT_W-1:0] C_MIN_WAIT = WAIT_W'(MIN_WAIT);

  logic [2:0]        r_state;
  logic              r_start_prev;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [RT_W-1:0]   r_rx_cnt;
  logic [7:0]        r_led;
  logic [RT_W-1:0]   r_rt;
  logic              r_cheat;
  logic              r_slow;
  logic              r_wait;
  logic              r_lcd_upd;
  logic              w_press;

  random_gen #(
    .LFSR_SEED(LFSR_SEED)
  ) u_random_gen (
    .Clk        (Clk),
    .Rst        (Rst),
    .RandomValue(RandomValue)
  );

  assign w_press = Start & ~r_start_prev;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_start_prev <= 1'b0;
    end else begin
      r_start_prev <= Start;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_rx_cnt   <= '0;
      r_led      <= LED_OFF;
      r_rt       <= '0;
      r_cheat    <= 1'b0;
      r_slow     <= 1'b0;
      r_wait     <= 1'b0;
      r_lcd_upd  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            r_rt       <= '0;
            r_cheat    <= 1'b0;
            r_slow     <= 1'b0;
            r_wait_cnt <= C_MIN_WAIT + {1'b0, RandomValue[11:0]};
            r_lcd_upd  <= ~LCDAck;
            r_state    <= S_ARM_UPD;
          end
        end
        // Request is only raised while the LCD side shows no stale Ack
        S_ARM_UPD, S_REP_UPD: begin
          if (r_lcd_upd && LCDAck) begin
            r_lcd_upd <= 1'b0;
            r_state   <= (r_state == S_ARM_UPD) ? S_ARM_REL : S_REP_REL;
          end else begin
            r_lcd_upd <= ~LCDAck;
          end
        end
        S_ARM_REL: begin
          if (!LCDAck) begin
            r_wait  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        // Wait stays high for exactly the latched number of cycles
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 1'b1;
          if (w_press) begin
            r_cheat   <= 1'b1;
            r_wait    <= 1'b0;
            r_lcd_upd <= ~LCDAck;
            r_state   <= S_REP_UPD;
          end else if (r_wait_cnt <= WAIT_W'(1)) begin
            r_wait   <= 1'b0;
            r_led    <= LED_ON;
            r_rx_cnt <= '0;
            r_state  <= S_GO;
          end
        end
        S_GO: begin
          if (w_press) begin
            r_rt      <= r_rx_cnt;
            r_slow    <= (r_rx_cnt >= C_SLOW_LIM);
            r_led     <= LED_OFF;
            r_lcd_upd <= ~LCDAck;
            r_state   <= S_REP_UPD;
          end else if (r_rx_cnt >= C_MAX_CNT) begin
            r_rt      <= C_MAX_CNT;
            r_slow    <= 1'b1;
            r_led     <= LED_OFF;
            r_lcd_upd <= ~LCDAck;
            r_state   <= S_REP_UPD;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_REP_REL: begin
          if (!LCDAck) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign LED          = r_led;
  assign ReactionTime = r_rt;
  assign Cheat        = r_cheat;
  assign Slow         = r_slow;
  assign Wait         = r_wait;
  assign LCDUpdate    = r_lcd_upd;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_system.sv
`default_nettype none
// ============================================================================
// tb_reaction_timer_system : scoreboard bench with an LCD Update/Ack responder
// Rev 1.0
// ============================================================================
module tb_reaction_timer_system;

  localparam logic [12:0] SEED      = 13'h1ACE;
  localparam int          K_REACT   = 0;
  localparam int          K_CHEAT   = 1;
  localparam int          K_TIMEOUT = 2;
  localparam int          K_RESET   = 3;

  typedef struct {
    int rt;
    int cheat;
    int slow;
  } exp_t;

  logic        Clk    = 1'b0;
  logic        Rst    = 1'b1;
  logic        Start  = 1'b0;
  logic        LCDAck = 1'b0;
  logic [7:0]  LED;
  logic [9:0]  ReactionTime;
  logic        Cheat;
  logic        Slow;
  logic        Wait;
  logic        LCDUpdate;
  logic [12:0] RandomValue;

  int          checks    = 0;
  int          errors    = 0;
  int          reports   = 0;
  bit          rep_phase = 1'b0;
  exp_t        sb[$];
  logic [12:0] lfsr_model;

  reaction_timer_system dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start       (Start),
    .LCDAck      (LCDAck),
    .LED         (LED),
    .ReactionTime(ReactionTime),
    .Cheat       (Cheat),
    .Slow        (Slow),
    .Wait        (Wait),
    .LCDUpdate   (LCDUpdate),
    .RandomValue (RandomValue)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [12:0] step(input logic [12:0] s);
    logic fb;
    fb = s[12] ^ s[11] ^ s[10] ^ s[7];
    return {s[11:0], fb};
  endfunction

  // Reference LFSR, compared every cycle while out of reset
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) lfsr_model <= SEED;
    else      lfsr_model <= (lfsr_model == 13'd0) ? SEED : step(lfsr_model);
  end

  always @(negedge Clk) begin
    if (Rst) check("lfsr_step", RandomValue, lfsr_model);
  end

  // LCD driver: arm requests must see cleared results, report requests pop the scoreboard
  initial begin : lcd_model
    int   n;
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst && LCDUpdate && !LCDAck) begin
        if (!rep_phase) begin
          check("arm_rt", ReactionTime, 0);
          check("arm_cheat", Cheat, 0);
          check("arm_slow", Slow, 0);
        end else begin
          check("sb_pending", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rep_rt", ReactionTime, e.rt);
            check("rep_cheat", Cheat, e.cheat);
            check("rep_slow", Slow, e.slow);
          end
          check("rep_led", LED, 0);
          check("rep_wait", Wait, 0);
        end
        repeat (2) @(negedge Clk);
        check("upd_held", LCDUpdate, 1);
        LCDAck = 1'b1;
        n = 0;
        while (LCDUpdate && n < 10) begin
          @(negedge Clk);
          n++;
        end
        check("upd_release", LCDUpdate, 0);
        @(negedge Clk);
        LCDAck = 1'b0;
        if (rep_phase) reports++;
        rep_phase = !rep_phase;
      end
    end
  end

  task automatic play(input int kind, input int d, input int hold);
    logic [12:0] rv;
    int          k;
    int          wcnt;
    int          n;
    int          prev;
    exp_t        e;
    prev = reports;
    @(negedge Clk);
    rv    = RandomValue;
    Start = 1'b1;
    case (kind)
      K_REACT: e = '{d, 0, (d >= 500) ? 1 : 0};
      K_CHEAT: e = '{0, 1, 0};
      default: e = '{1023, 0, 1};
    endcase
    if (kind != K_RESET) sb.push_back(e);
    k    = 0;
    wcnt = 0;
    while (LED != 8'hFF && k < 5300) begin
      @(negedge Clk);
      k++;
      if (k >= hold) Start = 1'b0;
      if (Wait) wcnt++;
      if (kind == K_CHEAT && wcnt == d) begin
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("cheat_led", LED, 0);
        check("cheat_wait", Wait, 0);
        break;
      end
    end
    if (kind != K_CHEAT) begin
      check("led_on", LED, 8'hFF);
      check("wait_len", wcnt, 1000 + int'(rv[11:0]));
    end
    if (kind == K_REACT) begin
      repeat (d) @(negedge Clk);
      check("go_led", LED, 8'hFF);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
    end else if (kind == K_TIMEOUT) begin
      n = 0;
      while (LED == 8'hFF && n < 1100) begin
        @(negedge Clk);
        n++;
      end
      check("go_cycles", n, 1024);
    end else if (kind == K_RESET) begin
      repeat (5) @(negedge Clk);
      #1 Rst = 1'b0;
      #1;
      check("rst_led", LED, 0);
      check("rst_wait", Wait, 0);
      check("rst_rt", ReactionTime, 0);
      check("rst_cheat", Cheat, 0);
      check("rst_slow", Slow, 0);
      check("rst_upd", LCDUpdate, 0);
      check("rst_rnd", RandomValue, SEED);
      @(negedge Clk);
      Rst       = 1'b1;
      rep_phase = 1'b0;
    end
    if (kind != K_RESET) begin
      n = 0;
      while (reports == prev && n < 200) begin
        @(negedge Clk);
        n++;
      end
      check("report_done", reports - prev, 1);
    end
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit zero_seen;
    bit early_wrap;
    #2 Rst = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_led", LED, 0);
    check("reset_rt", ReactionTime, 0);
    check("reset_cheat", Cheat, 0);
    check("reset_slow", Slow, 0);
    check("reset_wait", Wait, 0);
    check("reset_upd", LCDUpdate, 0);
    check("reset_rnd", RandomValue, SEED);
    Rst = 1'b1;
    @(negedge Clk);
    check("lfsr_first", RandomValue, step(SEED));
    zero_seen  = 1'b0;
    early_wrap = 1'b0;
    for (int i = 2; i <= 8191; i++) begin
      @(negedge Clk);
      if (RandomValue == 13'd0) zero_seen = 1'b1;
      if (i < 8191 && RandomValue == SEED) early_wrap = 1'b1;
    end
    check("lfsr_period", RandomValue, SEED);
    check("lfsr_nonzero", zero_seen, 0);
    check("lfsr_early_wrap", early_wrap, 0);

    play(K_REACT, 50, 150);
    play(K_REACT, 40, 1);
    play(K_CHEAT, 10, 1);
    play(K_REACT, 600, 1);
    play(K_REACT, 500, 1);
    play(K_REACT, 499, 1);
    play(K_REACT, 0, 1);
    play(K_TIMEOUT, 0, 1);
    play(K_RESET, 0, 1);
    sb.delete();
    play(K_REACT, 45, 1);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
